mem_access_stage: RTL and testbench

- Memory stage directly downstream of the EX/MEM pipeline register; upstream neighbour of writeback.
- Consumes EX/MEM outputs: ALU result as address, rs2 data as store data, plus control bits.
- Runs a req/ack handshake with a variable-latency data memory and stalls the pipeline until the access completes.
- Registers the MEM/WB outputs consumed by writeback.

---
 rtl/mem_access_stage.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory access stage: drives a req/ack data-memory handshake from the EX/MEM
// register, stalls upstream while the access is outstanding, and registers MEM/WB.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_mem_memread,
   input  logic        ex_mem_memwrite,
   input  logic        ex_mem_memtoreg,
   input  logic        ex_mem_regwrite,
   input  logic        ex_mem_regwrite_control_float,
   input  logic [4:0]  ex_mem_register_rd,
   input  logic        ex_mem_rd_sel,
   input  logic [31:0] result_ex_mem,
   input  logic [31:0] ex_mem_output_data_2,
   input  logic [2:0]  ex_mem_funct3,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic        misaligned_exc,
   output logic        bus_err,
   output logic        mem_wb_regwrite,
   output logic        mem_wb_regwrite_control_float,
   output logic        mem_wb_memtoreg,
   output logic        mem_wb_rd_sel,
   output logic [4:0]  mem_wb_register_rd,
   output logic [31:0] mem_wb_read_data,
   output logic [31:0] mem_wb_alu_result
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        mem_op, aligned, start, misalign, ack_hit, tmo_hit;
   logic [31:0] wdata_nxt;
   logic [3:0]  be_nxt;
   logic        wb_load, wb_kill_rw, wb_kill_mt;
   logic [31:0] wb_rdata;

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'd0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'd0, h};
         default: return w;
      endcase
   endfunction

   always_comb begin
      mem_op  = ex_mem_memread | ex_mem_memwrite;
      case (ex_mem_funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~result_ex_mem[0];
         default: aligned = (result_ex_mem[1:0] == 2'b00);
      endcase
      start    = (state == IDLE) && mem_op && aligned;
      misalign = (state == IDLE) && mem_op && !aligned;
      ack_hit  = (state == ACCESS) && dmem_ack;
      // Ack in the timeout cycle takes priority over the bus error.
      tmo_hit  = (state == ACCESS) && !dmem_ack && (cnt == 8'(TIMEOUT_CYCLES - 1));
      // Gated by rst_n so the stall drops immediately when reset is asserted.
      mem_stall = rst_n && (start || (state == ACCESS));
   end

   always_comb begin
      case (ex_mem_funct3)
         3'b000: begin
            wdata_nxt = {4{ex_mem_output_data_2[7:0]}};
            be_nxt    = 4'b0001 << result_ex_mem[1:0];
         end
         3'b001: begin
            wdata_nxt = {2{ex_mem_output_data_2[15:0]}};
            be_nxt    = 4'b0011 << result_ex_mem[1:0];
         end
         default: begin
            wdata_nxt = ex_mem_output_data_2;
            be_nxt    = 4'b1111;
         end
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACCESS;
         ACCESS:  if (ack_hit || tmo_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wb_load    = 1'b1;
      wb_kill_rw = 1'b0;
      wb_kill_mt = 1'b0;
      wb_rdata   = 32'd0;
      case (state)
         IDLE: begin
            wb_kill_rw = start | misalign;
            wb_kill_mt = start;
         end
         ACCESS: wb_load = 1'b0;
         RESP: begin
            wb_kill_rw = err_q;
            wb_rdata   = rdata_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt            <= '0;
         rdata_q        <= '0;
         err_q          <= 1'b0;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_wdata     <= '0;
         dmem_be        <= '0;
         misaligned_exc <= 1'b0;
         bus_err        <= 1'b0;
      end else begin
         misaligned_exc <= misalign;
         bus_err        <= tmo_hit;
         cnt            <= (state == ACCESS) ? cnt + 8'd1 : 8'd0;
         if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_memwrite;
            dmem_addr  <= {result_ex_mem[31:2], 2'b00};
            dmem_wdata <= wdata_nxt;
            dmem_be    <= be_nxt;
            rdata_q    <= '0;
            err_q      <= 1'b0;
         end
         if (ack_hit) begin
            dmem_req <= 1'b0;
            rdata_q  <= dmem_we ? 32'd0 : load_ext(dmem_rdata, result_ex_mem[1:0], ex_mem_funct3);
         end else if (tmo_hit) begin
            dmem_req <= 1'b0;
            err_q    <= 1'b1;
            rdata_q  <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_wb_regwrite               <= 1'b0;
         mem_wb_regwrite_control_float <= 1'b0;
         mem_wb_memtoreg               <= 1'b0;
         mem_wb_rd_sel                 <= 1'b0;
         mem_wb_register_rd            <= '0;
         mem_wb_read_data              <= '0;
         mem_wb_alu_result             <= '0;
      end else if (wb_load) begin
         mem_wb_regwrite               <= ex_mem_regwrite & ~wb_kill_rw;
         mem_wb_regwrite_control_float <= ex_mem_regwrite_control_float & ~wb_kill_rw;
         mem_wb_memtoreg               <= ex_mem_memtoreg & ~wb_kill_mt;
         mem_wb_rd_sel                 <= ex_mem_rd_sel;
         mem_wb_register_rd            <= ex_mem_register_rd;
         mem_wb_read_data              <= wb_rdata;
         mem_wb_alu_result             <= result_ex_mem;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT_CYCLES=4.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        memread, memwrite, memtoreg, regwrite, fregwrite, rd_sel;
   logic [4:0]  rd;
   logic [31:0] result, data2;
   logic [2:0]  funct3;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        mem_stall, misaligned_exc, bus_err;
   logic        wb_rw, wb_frw, wb_mt, wb_rdsel;
   logic [4:0]  wb_rd;
   logic [31:0] wb_rdata, wb_alu;

   int errs = 0, checks = 0;
   int req_n, stall_n, bus_n;
   logic [31:0] c_addr, c_wdata;
   logic [3:0]  c_be;
   logic        c_we;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_mem_memread(memread), .ex_mem_memwrite(memwrite), .ex_mem_memtoreg(memtoreg),
      .ex_mem_regwrite(regwrite), .ex_mem_regwrite_control_float(fregwrite),
      .ex_mem_register_rd(rd), .ex_mem_rd_sel(rd_sel), .result_ex_mem(result),
      .ex_mem_output_data_2(data2), .ex_mem_funct3(funct3),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall), .misaligned_exc(misaligned_exc), .bus_err(bus_err),
      .mem_wb_regwrite(wb_rw), .mem_wb_regwrite_control_float(wb_frw),
      .mem_wb_memtoreg(wb_mt), .mem_wb_rd_sel(wb_rdsel), .mem_wb_register_rd(wb_rd),
      .mem_wb_read_data(wb_rdata), .mem_wb_alu_result(wb_alu)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic mr, input logic mw, input logic mt, input logic rw,
                         input logic [4:0] r, input logic [31:0] res, input logic [31:0] d2,
                         input logic [2:0] f3);
      memread = mr; memwrite = mw; memtoreg = mt; regwrite = rw; fregwrite = 1'b0;
      rd = r; rd_sel = 1'b0; result = res; data2 = d2; funct3 = f3;
   endtask

   task automatic nop();
      set_op(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 3'b000);
   endtask

   // Op already driven; ack_at=0 means no ack. Ends just after the MEM/WB update edge.
   task automatic mem_txn(input int ack_at, input logic [31:0] rd_word);
      req_n = 0; stall_n = 0; bus_n = 0;
      #1;
      if (mem_stall) stall_n++;
      step();
      c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be; c_we = dmem_we;
      for (int k = 1; k <= 20; k++) begin
         if (!dmem_req) break;
         req_n++;
         if (mem_stall) stall_n++;
         if (k == ack_at) begin dmem_ack = 1'b1; dmem_rdata = rd_word; end
         step();
         dmem_ack = 1'b0;
      end
      if (mem_stall) stall_n++;
      if (bus_err) bus_n++;
      step();
      if (bus_err) bus_n++;
   endtask

   initial begin
      dmem_ack = 1'b0; dmem_rdata = 32'd0;
      nop();
      step(); step();
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_wb_alu", wb_alu, 32'd0);
      rst_n = 1'b1;
      step();

      // plain ALU op
      set_op(0, 0, 0, 1, 5'd5, 32'h0000_1234, 32'd0, 3'b010);
      #1 chk("alu_stall", {31'd0, mem_stall}, 32'd0);
      step();
      chk("alu_result", wb_alu, 32'h0000_1234);
      chk("alu_rw", {31'd0, wb_rw}, 32'd1);
      chk("alu_rd", {27'd0, wb_rd}, 32'd5);
      chk("alu_stall2", {31'd0, mem_stall}, 32'd0);

      // SW with ack on 3rd ACCESS cycle
      set_op(0, 1, 0, 0, 5'd0, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010);
      mem_txn(3, 32'h0);
      chk("sw_req_cyc", req_n, 3);
      chk("sw_stall_cyc", stall_n, 4);
      chk("sw_be", {28'd0, c_be}, 32'hF);
      chk("sw_we", {31'd0, c_we}, 32'd1);
      chk("sw_addr", c_addr, 32'h0000_0100);
      chk("sw_wdata", c_wdata, 32'hDEAD_BEEF);
      chk("sw_wb_rw", {31'd0, wb_rw}, 32'd0);

      // LW with ack on first ACCESS cycle
      set_op(1, 0, 1, 1, 5'd7, 32'h0000_0100, 32'd0, 3'b010);
      mem_txn(1, 32'hDEAD_BEEF);
      chk("lw_data", wb_rdata, 32'hDEAD_BEEF);
      chk("lw_mt", {31'd0, wb_mt}, 32'd1);
      chk("lw_rw", {31'd0, wb_rw}, 32'd1);
      chk("lw_lat", stall_n, 2);

      // sub-word loads/stores
      set_op(1, 0, 1, 1, 5'd8, 32'h0000_0103, 32'd0, 3'b000);
      mem_txn(2, 32'h80AA_BBCC);
      chk("lb_data", wb_rdata, 32'hFFFF_FF80);
      set_op(1, 0, 1, 1, 5'd8, 32'h0000_0103, 32'd0, 3'b100);
      mem_txn(1, 32'h80AA_BBCC);
      chk("lbu_data", wb_rdata, 32'h0000_0080);
      set_op(1, 0, 1, 1, 5'd8, 32'h0000_0102, 32'd0, 3'b001);
      mem_txn(1, 32'h80AA_BBCC);
      chk("lh_data", wb_rdata, 32'hFFFF_80AA);
      set_op(0, 1, 0, 0, 5'd0, 32'h0000_0102, 32'h0000_005A, 3'b000);
      mem_txn(1, 32'h0);
      chk("sb_be", {28'd0, c_be}, 32'h4);
      chk("sb_wdata", c_wdata, 32'h5A5A_5A5A);
      chk("sb_addr", c_addr, 32'h0000_0100);
      set_op(0, 1, 0, 0, 5'd0, 32'h0000_0102, 32'h0000_1234, 3'b001);
      mem_txn(1, 32'h0);
      chk("sh_be", {28'd0, c_be}, 32'hC);
      chk("sh_wdata", c_wdata, 32'h1234_1234);

      // misaligned LW
      set_op(1, 0, 1, 1, 5'd3, 32'h0000_1002, 32'd0, 3'b010);
      #1 chk("mis_stall", {31'd0, mem_stall}, 32'd0);
      step();
      nop();
      chk("mis_req", {31'd0, dmem_req}, 32'd0);
      chk("mis_exc", {31'd0, misaligned_exc}, 32'd1);
      chk("mis_rw", {31'd0, wb_rw}, 32'd0);
      step();
      chk("mis_exc_pulse", {31'd0, misaligned_exc}, 32'd0);

      // timeout, then ack exactly at the timeout cycle
      set_op(1, 0, 1, 1, 5'd4, 32'h0000_0200, 32'd0, 3'b010);
      mem_txn(0, 32'h0);
      chk("tmo_req_cyc", req_n, 4);
      chk("tmo_bus_err", bus_n, 1);
      chk("tmo_rw", {31'd0, wb_rw}, 32'd0);
      chk("tmo_rdata", wb_rdata, 32'd0);
      set_op(0, 0, 0, 1, 5'd9, 32'h0000_ABCD, 32'd0, 3'b010);
      step();
      chk("post_tmo_alu", wb_alu, 32'h0000_ABCD);
      chk("post_tmo_rw", {31'd0, wb_rw}, 32'd1);
      set_op(1, 0, 1, 1, 5'd4, 32'h0000_0200, 32'd0, 3'b010);
      mem_txn(4, 32'h1122_3344);
      chk("ackwin_data", wb_rdata, 32'h1122_3344);
      chk("ackwin_rw", {31'd0, wb_rw}, 32'd1);
      chk("ackwin_bus", bus_n, 0);

      // reset in the middle of an access
      set_op(1, 0, 1, 1, 5'd6, 32'h0000_0300, 32'd0, 3'b010);
      step();
      chk("mid_req", {31'd0, dmem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_mid_alu", wb_alu, 32'd0);
      chk("rst_mid_rw", {31'd0, wb_rw}, 32'd0);
      nop();
      step();
      rst_n = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      step();
      dmem_ack = 1'b0;
      step();
      chk("late_ack_rdata", wb_rdata, 32'd0);
      chk("late_ack_rw", {31'd0, wb_rw}, 32'd0);
      chk("late_ack_req", {31'd0, dmem_req}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
